// File: rtl/adder.sv
// Ripple-carry add/subtract unit with compare flags and a registered copy of every result.
// Gate delays are not modelled here; the combinational path is a pure n-stage carry chain.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module adder #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [n-1:0] X,
  input  logic [n-1:0] Y,
  input  logic         Nadd_sub,
  output logic [n-1:0] sum,
  output logic         carry,
  output logic         overflow,
  output logic         eq,
  output logic         lt,
  output logic         ltu,
  output logic [n-1:0] sum_q,
  output logic         carry_q,
  output logic         overflow_q,
  output logic         eq_q,
  output logic         lt_q,
  output logic         ltu_q
);

  logic [n:0]   c;
  logic [n-1:0] b_in;
  logic [n-1:0] p;
  logic [n-1:0] g;
  logic [n-1:0] t;
  logic [n-1:0] s;

  // Subtract is X + ~Y + 1: invert B per stage and inject the +1 as carry-in.
  assign c[0] = Nadd_sub;

  for (genvar i = 0; i < n; i++) begin : g_stage
    assign b_in[i] = Y[i] ^ Nadd_sub;

    half_adder u_ha0 (
      .a     (X[i]),
      .b     (b_in[i]),
      .sum   (p[i]),
      .carry (g[i])
    );

    half_adder u_ha1 (
      .a     (p[i]),
      .b     (c[i]),
      .sum   (s[i]),
      .carry (t[i])
    );

    assign c[i+1] = g[i] | t[i];
  end

  assign sum      = s;
  assign carry    = c[n];
  assign overflow = c[n] ^ c[n-1];

  // Compare flags only carry meaning in subtract mode; forced low when adding.
  assign eq  = Nadd_sub & (s == '0);
  assign lt  = Nadd_sub & (s[n-1] ^ overflow);
  assign ltu = Nadd_sub & ~c[n];

  logic [n-1:0] sum_d;
  logic         carry_d;
  logic         overflow_d;
  logic         eq_d;
  logic         lt_d;
  logic         ltu_d;

  assign sum_d      = sum;
  assign carry_d    = carry;
  assign overflow_d = overflow;
  assign eq_d       = eq;
  assign lt_d       = lt;
  assign ltu_d      = ltu;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q      <= '0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
      ltu_q      <= 1'b0;
    end else begin
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      eq_q       <= eq_d;
      lt_q       <= lt_d;
      ltu_q      <= ltu_d;
    end
  end

endmodule

// File: tb/tb_adder.sv
// Bench for adder: directed vector table, half_adder truth table, reset sequence,
// and randomized operands checked against an arithmetic reference model.

module tb_adder;
  localparam int N = 4;

  typedef struct {
    logic [N-1:0] x;
    logic [N-1:0] y;
    logic         mode;
    logic [N-1:0] sum;
    logic         carry;
    logic         ovf;
    logic         eq;
    logic         lt;
    logic         ltu;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [N-1:0] x;
  logic [N-1:0] y;
  logic         mode;
  logic [N-1:0] sum;
  logic         carry;
  logic         overflow;
  logic         eq;
  logic         lt;
  logic         ltu;
  logic [N-1:0] sum_q;
  logic         carry_q;
  logic         overflow_q;
  logic         eq_q;
  logic         lt_q;
  logic         ltu_q;
  logic         ha_a;
  logic         ha_b;
  logic         ha_s;
  logic         ha_c;

  int n_vec = 0;
  int n_err = 0;

  adder #(.n(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .X          (x),
    .Y          (y),
    .Nadd_sub   (mode),
    .sum        (sum),
    .carry      (carry),
    .overflow   (overflow),
    .eq         (eq),
    .lt         (lt),
    .ltu        (ltu),
    .sum_q      (sum_q),
    .carry_q    (carry_q),
    .overflow_q (overflow_q),
    .eq_q       (eq_q),
    .lt_q       (lt_q),
    .ltu_q      (ltu_q)
  );

  half_adder ha_u (
    .a     (ha_a),
    .b     (ha_b),
    .sum   (ha_s),
    .carry (ha_c)
  );

  // Clock: rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model from plain integer arithmetic.
  function automatic vec_t model(input logic [N-1:0] xa, input logic [N-1:0] ya, input logic m);
    vec_t r;
    int   ux;
    int   uy;
    int   sx;
    int   sy;
    int   full;
    int   sres;
    ux = int'(xa);
    uy = int'(ya);
    sx = (ux >= (1 << (N - 1))) ? ux - (1 << N) : ux;
    sy = (uy >= (1 << (N - 1))) ? uy - (1 << N) : uy;
    r.x = xa;
    r.y = ya;
    r.mode = m;
    if (!m) begin
      full = ux + uy;
      sres = sx + sy;
      r.eq = 1'b0;
      r.lt = 1'b0;
      r.ltu = 1'b0;
    end else begin
      full = ux + ((1 << N) - 1 - uy) + 1;
      sres = sx - sy;
      r.eq = (ux == uy);
      r.lt = (sx < sy);
      r.ltu = (ux < uy);
    end
    r.sum = N'(full % (1 << N));
    r.carry = (full >= (1 << N));
    r.ovf = (sres > (1 << (N - 1)) - 1) || (sres < -(1 << (N - 1)));
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (X=%0d Y=%0d sub=%0b)", name, act, exp, x, y, mode);
    end
  endtask

  task automatic chk_comb(input vec_t e);
    chk("sum", 32'(sum), 32'(e.sum));
    chk("carry", 32'(carry), 32'(e.carry));
    chk("overflow", 32'(overflow), 32'(e.ovf));
    chk("eq", 32'(eq), 32'(e.eq));
    chk("lt", 32'(lt), 32'(e.lt));
    chk("ltu", 32'(ltu), 32'(e.ltu));
  endtask

  task automatic chk_regs(input vec_t e);
    chk("sum_q", 32'(sum_q), 32'(e.sum));
    chk("carry_q", 32'(carry_q), 32'(e.carry));
    chk("overflow_q", 32'(overflow_q), 32'(e.ovf));
    chk("eq_q", 32'(eq_q), 32'(e.eq));
    chk("lt_q", 32'(lt_q), 32'(e.lt));
    chk("ltu_q", 32'(ltu_q), 32'(e.ltu));
  endtask

  task automatic chk_regs_zero();
    vec_t z;
    z = '{x: '0, y: '0, mode: 1'b0, sum: '0, carry: 1'b0, ovf: 1'b0, eq: 1'b0, lt: 1'b0, ltu: 1'b0};
    chk_regs(z);
  endtask

  task automatic drive(input logic [N-1:0] xa, input logic [N-1:0] ya, input logic m);
    x = xa;
    y = ya;
    mode = m;
  endtask

  vec_t vecs[7];
  vec_t e;

  initial begin
    // Directed table: x, y, mode, sum, carry, ovf, eq, lt, ltu
    vecs[0] = '{4'd15, 4'd15, 1'b0, 4'd14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{4'd9,  4'd14, 1'b0, 4'd7,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{4'd4,  4'd3,  1'b1, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{4'd3,  4'd4,  1'b1, 4'd15, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{4'd4,  4'd11, 1'b1, 4'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{4'd9,  4'd3,  1'b1, 4'd6,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{4'd15, 4'd15, 1'b1, 4'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(4'd0, 4'd0, 1'b0);
    ha_a = 1'b0;
    ha_b = 1'b0;

    // Registered copies are cleared while reset is held.
    @(posedge clk);
    #1;
    chk_regs_zero();

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      drive(vecs[i].x, vecs[i].y, vecs[i].mode);
      #1;
      chk_comb(vecs[i]);
    end

    for (int i = 0; i < 4; i++) begin
      ha_a = i[1];
      ha_b = i[0];
      #1;
      chk("ha_sum", 32'(ha_s), 32'(i[1] ^ i[0]));
      chk("ha_carry", 32'(ha_c), 32'(i[1] & i[0]));
    end

    // Capture, asynchronous clear mid-cycle, hold through an edge, recapture.
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'd4, 4'd3, 1'b1);
    e = model(4'd4, 4'd3, 1'b1);
    @(posedge clk);
    #1;
    chk("seq_sum_q", 32'(sum_q), 32'd1);
    chk("seq_carry_q", 32'(carry_q), 32'd1);
    chk_regs(e);
    #2;
    rst_n = 1'b0;
    #1;
    chk_regs_zero();
    chk_comb(e);
    @(posedge clk);
    #1;
    chk_regs_zero();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_regs_zero();
    @(posedge clk);
    #1;
    chk_regs(e);

    // Randomized operands; roughly one in eight forces X == Y to hit eq.
    for (int i = 0; i < 300; i++) begin
      logic [N-1:0] rx;
      logic [N-1:0] ry;
      logic         rm;
      @(negedge clk);
      rx = N'($urandom_range(0, (1 << N) - 1));
      ry = ($urandom_range(0, 7) == 0) ? rx : N'($urandom_range(0, (1 << N) - 1));
      rm = 1'($urandom_range(0, 1));
      drive(rx, ry, rm);
      e = model(rx, ry, rm);
      #1;
      chk_comb(e);
      @(posedge clk);
      #1;
      chk_regs(e);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/adder.md
ADDER -- requirements
Module: adder

Interface
REQ-001 Parameter: n, default 4, operand/result width in bits (n >= 2).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port: clk  input  1  clock; used only by the registered output copy.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset of the registered copy.
REQ-005 Port: X  input  n  operand A.
REQ-006 Port: Y  input  n  operand B.
REQ-007 Port: Nadd_sub  input  1  mode select: 0 = add, 1 = subtract/compare.
REQ-008 Port: sum  output  n  combinational result.
REQ-009 Port: carry  output  1  combinational raw carry-out of the MSB stage.
REQ-010 Port: overflow  output  1  combinational two's-complement overflow.
REQ-011 Port: eq, lt, ltu  output  1 each  combinational compare flags: X==Y, signed X<Y, unsigned X<Y.
REQ-012 Port: sum_q, carry_q, overflow_q, eq_q, lt_q, ltu_q  output  n/1  registered copies of the combinational outputs.

Function
REQ-013 Datapath SHALL be an n-stage ripple-carry chain of full adders, each built from two half_adder instances plus an OR gate for carry.
REQ-014 half_adder (ports a, b, sum, carry) SHALL give sum = a XOR b, carry = a AND b.
REQ-015 Stage i B-input SHALL be Y[i] XOR Nadd_sub; stage 0 carry-in SHALL be Nadd_sub.
REQ-016 Add mode: sum = (X+Y) mod 2^n; carry = bit n of X+Y.
REQ-017 Subtract mode: sum = (X + ~Y + 1) mod 2^n; carry = raw carry-out (1 when X >= Y unsigned), not inverted.
REQ-018 overflow SHALL equal carry-into-MSB XOR carry-out-of-MSB in both modes.
REQ-019 Subtract mode: eq = 1 iff sum == 0; lt = sum[n-1] XOR overflow; ltu = NOT carry.
REQ-020 Add mode: eq, lt, ltu SHALL be driven to 0.
REQ-021 Gates SHALL use the codebase T_DELAY_PD per-gate delay; adder outputs SHALL settle within 3*n*T_DELAY_PD after any input change; half_adder within 2*T_DELAY_PD.
REQ-022 Combinational outputs SHALL not depend on clk or rst_n.
REQ-023 On each rising clk edge with rst_n high, every *_q output SHALL capture its combinational counterpart; latency one cycle.
REQ-024 Wrap-around: results wider than n bits SHALL be truncated to n bits; the excess bit appears only on carry.

Reset
REQ-025 rst_n low SHALL immediately clear all *_q outputs to 0, independent of clk, including mid-operation.
REQ-026 While rst_n is low the *_q outputs SHALL hold 0; the first rising edge after release SHALL capture current results.
REQ-027 Reset SHALL NOT affect sum, carry, overflow, eq, lt, ltu.

Verification
REQ-028 n=4, add, X=15, Y=15 -> sum=14, carry=1, overflow=0, eq=lt=ltu=0.
REQ-029 add, X=9 (-7), Y=14 (-2) -> sum=7, carry=1, overflow=1.
REQ-030 sub, X=4, Y=3 -> sum=1, carry=1, overflow=0, eq=0, lt=0, ltu=0; X=3, Y=4 -> sum=15, carry=0, lt=1, ltu=1.
REQ-031 sub, X=4, Y=11 (-5) -> sum=9, carry=0, overflow=1, lt=0, ltu=1; X=9 (-7), Y=3 -> sum=6, carry=1, overflow=1, lt=1, ltu=0.
REQ-032 sub, X=15, Y=15 -> sum=0, carry=1, eq=1, lt=0, ltu=0; half_adder all four a/b combinations -> sum=a^b, carry=a&b.
REQ-033 Apply X=4, Y=3 sub, clock once -> sum_q=1, carry_q=1; assert rst_n low between edges -> all *_q=0 at once; release, one edge -> values recaptured.
